// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_t;

    // Baud codes understood by the transmitter.
    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;
    localparam logic [2:0] BAUD_230400 = 3'd5;
    localparam logic [2:0] BAUD_460800 = 3'd6;
    localparam logic [2:0] BAUD_921600 = 3'd7;

    // Bit-times per frame: start, 8 data, parity, stop.
    localparam int unsigned FRAME_BITS = 11;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or above rr_ptr, wrapping mod N.
module rr_picker #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] rr_ptr,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    int unsigned idx;

    // Scan requesters starting at rr_ptr; the first hit wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(rr_ptr) + i) % N;
            if (!gnt_valid && req[IDW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_id    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N byte producers,
// tracking each frame through tx_busy and owning enable/baud configuration.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned IDW     = $clog2(N),
    parameter int unsigned TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [2:0]     cfg_baud,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   done,
    output logic [IDW-1:0] grant_id,
    output logic           active,
    output logic           err,
    output logic           tx_en,
    output logic           tx_wr,
    output logic [7:0]     tx_data,
    output logic [2:0]     baud_select,
    input  logic           tx_busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_t     state, state_d;
    logic           en_q;
    logic [IDW-1:0] rr_ptr, rr_ptr_d;
    logic [CW-1:0]  cnt, cnt_d;

    logic [N-1:0]   ack_d, done_d;
    logic [IDW-1:0] grant_id_d;
    logic           active_d, err_d, tx_wr_d;
    logic [7:0]     tx_data_d;
    logic [2:0]     baud_d;

    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // en_q doubles as the registered transmitter enable.
    assign tx_en = en_q;

    // Next-state and next-output decode; outputs are computed for the state being
    // entered so the registered strobes line up with ISSUE and DONE.
    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        cnt_d      = cnt;
        ack_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
        tx_wr_d    = 1'b0;
        grant_id_d = grant_id;
        active_d   = active;
        tx_data_d  = tx_data;
        baud_d     = baud_select;

        case (state)
            ST_IDLE: begin
                baud_d = cfg_baud;
                if (gnt_valid && enable && en_q) begin
                    tx_data_d      = req_data[{gnt_id, 3'b000} +: 8];
                    grant_id_d     = gnt_id;
                    active_d       = 1'b1;
                    ack_d[gnt_id]  = 1'b1;
                    tx_wr_d        = 1'b1;
                    rr_ptr_d       = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d[grant_id] = 1'b1;
                    active_d         = 1'b0;
                    state_d          = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            en_q        <= 1'b0;
            rr_ptr      <= '0;
            cnt         <= '0;
            ack         <= '0;
            done        <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            err         <= 1'b0;
            tx_wr       <= 1'b0;
            tx_data     <= '0;
            baud_select <= '0;
        end else begin
            state       <= state_d;
            en_q        <= enable;
            rr_ptr      <= rr_ptr_d;
            cnt         <= cnt_d;
            ack         <= ack_d;
            done        <= done_d;
            grant_id    <= grant_id_d;
            active      <= active_d;
            err         <= err_d;
            tx_wr       <= tx_wr_d;
            tx_data     <= tx_data_d;
            baud_select <= baud_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple serial transmitter model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int unsigned N       = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned BIT_CYC = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [2:0]     cfg_baud;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack, done;
    logic [IDW-1:0] grant_id;
    logic           active, err, tx_en, tx_wr;
    logic [7:0]     tx_data;
    logic [2:0]     baud_select;
    logic           tx_busy;

    logic           model_on;
    logic [10:0]    shreg;
    logic [10:0]    rx;
    int unsigned    busy_cnt;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .N       (N),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_baud    (cfg_baud),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .grant_id    (grant_id),
        .active      (active),
        .err         (err),
        .tx_en       (tx_en),
        .tx_wr       (tx_wr),
        .tx_data     (tx_data),
        .baud_select (baud_select),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    // Transmitter model: latches tx_data on tx_wr, stays busy for a full frame,
    // and collects the serial line LSB-first into rx.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
            shreg    <= '1;
            rx       <= '0;
        end else if (!tx_busy) begin
            if (tx_wr && model_on) begin
                shreg    <= {1'b1, ^tx_data, tx_data, 1'b0};
                rx       <= '0;
                tx_busy  <= 1'b1;
                busy_cnt <= FRAME_BITS * BIT_CYC - 1;
            end
        end else begin
            if (busy_cnt % BIT_CYC == 0) begin
                rx    <= {shreg[0], rx[10:1]};
                shreg <= {1'b1, shreg[10:1]};
            end
            if (busy_cnt == 0) tx_busy <= 1'b0;
            else               busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_wr(input string tag);
        int n = 0;
        while (tx_wr !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 60), 32'd1);
    endtask

    task automatic wait_done(input string tag, input logic [7:0] hold, input logic [N-1:0] exp_done);
        int n = 0;
        while (tx_busy === 1'b1 && n < 100) begin
            chk({tag, "_hold"}, 32'(tx_data), 32'(hold));
            step();
            n++;
        end
        chk({tag, "_busy_fell"}, 32'(n < 100), 32'd1);
        n = 0;
        while (done === '0 && n < 5) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
    endtask

    int unsigned rr_ids[4] = '{0, 2, 3, 0};
    logic [7:0]  rr_dat[4] = '{8'h11, 8'h33, 8'h44, 8'h11};

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        cfg_baud = BAUD_9600;
        req      = '0;
        req_data = '0;
        model_on = 1'b1;
        step(2);

        chk("rst_ack",   32'(ack),         32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_gid",   32'(grant_id),    32'd0);
        chk("rst_act",   32'(active),      32'd0);
        chk("rst_err",   32'(err),         32'd0);
        chk("rst_txen",  32'(tx_en),       32'd0);
        chk("rst_wr",    32'(tx_wr),       32'd0);
        chk("rst_data",  32'(tx_data),     32'd0);
        chk("rst_baud",  32'(baud_select), 32'd0);

        // Single request with enable warm-up and mid-frame baud change.
        reset    = 1'b0;
        req      = 4'b0010;
        req_data = 32'h0000_A500;
        step(2);
        chk("off_no_wr", 32'(tx_wr), 32'd0);
        chk("off_txen",  32'(tx_en), 32'd0);
        enable = 1'b1;
        step();
        chk("warm_txen",  32'(tx_en), 32'd1);
        chk("warm_no_wr", 32'(tx_wr), 32'd0);
        step();
        chk("s_wr",   32'(tx_wr),       32'd1);
        chk("s_ack",  32'(ack),         32'h2);
        chk("s_data", 32'(tx_data),     32'hA5);
        chk("s_gid",  32'(grant_id),    32'd1);
        chk("s_act",  32'(active),      32'd1);
        req = '0;
        step();
        chk("s_wr_pulse",  32'(tx_wr), 32'd0);
        chk("s_ack_pulse", 32'(ack),   32'd0);
        cfg_baud = BAUD_921600;
        step();
        chk("s_baud_held", 32'(baud_select), 32'd0);
        while (tx_busy === 1'b1 && total < 200) begin
            chk("s_hold", 32'(tx_data), 32'hA5);
            step();
        end
        chk("s_busy_fell",  32'(tx_busy), 32'd0);
        chk("s_pre_done",   32'(done),    32'd0);
        chk("s_pre_act",    32'(active),  32'd1);
        step();
        chk("s_done",       32'(done),        32'h2);
        chk("s_done_act",   32'(active),      32'd0);
        chk("s_done_baud",  32'(baud_select), 32'd0);
        step();
        chk("s_done_pulse", 32'(done), 32'd0);
        step();
        chk("s_baud_new",   32'(baud_select), 32'd7);
        chk("s_frame",      32'(rx), 32'(11'b1_0_10100101_0));

        // Round-robin with three requesters held from reset.
        reset    = 1'b1;
        req      = 4'b1101;
        req_data = {8'h44, 8'h33, 8'h00, 8'h11};
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_wr("rr_wr");
            chk("rr_gid",  32'(grant_id), 32'(rr_ids[k]));
            chk("rr_data", 32'(tx_data),  32'(rr_dat[k]));
            chk("rr_ack",  32'(ack),      32'(1 << rr_ids[k]));
            step();
            wait_done("rr", rr_dat[k], N'(1 << rr_ids[k]));
        end

        // Reset mid-frame: next grant is requester 2.
        wait_wr("mr_wr");
        chk("mr_gid", 32'(grant_id), 32'd2);
        step(3);
        chk("mr_in_frame", 32'(active), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mr_act",  32'(active),      32'd0);
        chk("mr_data", 32'(tx_data),     32'd0);
        chk("mr_gid0", 32'(grant_id),    32'd0);
        chk("mr_baud", 32'(baud_select), 32'd0);
        chk("mr_txen", 32'(tx_en),       32'd0);
        step();
        chk("mr_no_done", 32'(done), 32'd0);
        reset = 1'b0;
        wait_wr("mr_wr2");
        chk("mr_gid_after", 32'(grant_id), 32'd0);
        chk("mr_data_after", 32'(tx_data), 32'h11);
        step();
        wait_done("mr", 8'h11, 4'b0001);

        // Timeout: transmitter never goes busy.
        req      = 4'b0100;
        model_on = 1'b0;
        wait_wr("to_wr");
        chk("to_ack", 32'(ack),      32'h4);
        chk("to_gid", 32'(grant_id), 32'd2);
        req = '0;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            step();
            chk("to_no_err", 32'(err), 32'd0);
        end
        step();
        chk("to_err",     32'(err),    32'd1);
        chk("to_act",     32'(active), 32'd0);
        chk("to_no_done", 32'(done),   32'd0);
        chk("to_no_ack",  32'(ack),    32'd0);
        step();
        chk("to_err_pulse", 32'(err),   32'd0);
        chk("to_idle_wr",   32'(tx_wr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among N byte-producing requesters using round-robin arbitration. Each winning byte is captured into a holding register and issued with a one-cycle write strobe. The block then tracks the transmitter busy flag through the complete frame and reports completion to the winning requester. It also owns the transmitter enable and baud configuration, and changes baud only between frames.

Parameters:
N, 4, number of requesters (2..8)
IDW, $clog2(N), grant index width
TIMEOUT, 8, max cycles in WAIT_BUSY for tx_busy to rise before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  global transmit enable
cfg_baud  in  3  requested baud code
req  in  N  per-requester byte valid (level)
req_data  in  8*N  byte for requester i at bits [8i+7:8i]
ack  out  N  one-cycle pulse: byte of requester i captured
done  out  N  one-cycle pulse: frame of requester i fully sent
grant_id  out  IDW  index of current owner (valid while active=1)
active  out  1  frame in progress
err  out  1  one-cycle pulse: tx_busy timeout, byte dropped
tx_en  out  1  transmitter enable
tx_wr  out  1  transmitter write strobe
tx_data  out  8  byte to transmitter, stable for whole frame
baud_select  out  3  baud code to transmitter
tx_busy  in  1  transmitter busy flag

Behaviour:
- All outputs are registered. On reset, every output is 0, state=IDLE, rr_ptr=0, en_q=0, and the timeout counter is 0. Reset mid-frame aborts the frame with no done and no err.
- en_q is enable delayed one cycle. tx_en = enable, registered (one-cycle delay).
- A grant is allowed only when enable=1 and en_q=1, so the transmitter is out of its off state before the strobe.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE: baud_select <= cfg_baud every cycle. If any req is high and the grant is allowed, choose the first set req scanning from rr_ptr upward mod N.
  - Capture req_data of the winner into tx_data, set grant_id and active=1.
  - Set rr_ptr <= winner+1 mod N, then go to ISSUE.
- ISSUE (exactly 1 cycle): tx_wr=1 and ack[grant_id]=1, then go to WAIT_BUSY with the counter cleared. The requester may change req/req_data from the next cycle; holding req high is a new request.
- WAIT_BUSY:
  - tx_busy=1 -> go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with tx_busy still 0, pulse err, set active=0 and go to IDLE. No done is issued.
- WAIT_DONE: hold tx_data. When tx_busy is sampled 0, go to DONE.
- DONE (1 cycle): done[grant_id]=1 and active=0, then go to IDLE. The earliest next ISSUE is 2 cycles after DONE.
- Latency: req rises in IDLE at cycle t -> tx_wr at t+1 -> tx_busy expected at t+2.
- Baud changes: a cfg_baud change during a frame is not applied until IDLE.
- enable falling mid-frame: the current frame completes normally; no new grant is made while enable=0.
- At most one ack bit and one done bit are high in any cycle. ack and done never overlap with err.
- Simultaneous requests: strictly round-robin, so no requester waits more than N-1 frames.

Decomposition:
- Shared package uart_pkg holds:
  - arbiter state encoding localparams;
  - baud code constants (3-bit);
  - frame length constant (11 bit-times: start, 8 data, parity, stop).
- One sub-module, rr_picker: combinational round-robin selector with inputs req[N] and rr_ptr[IDW], outputs gnt_valid and gnt_id[IDW]. Everything else stays in the top.

Test Plan:
- Single request: enable held 2+ cycles, req[1]=1, data 0xA5. Expect:
  - tx_wr pulse one cycle after capture, ack[1] in the same cycle, tx_data=0xA5;
  - with the real transmitter attached, the serial frame is 0, 1,0,1,0,0,1,0,1, parity 0, stop 1;
  - done[1] after tx_busy falls.
- Round-robin: req[0], req[2] and req[3] all held high with data 0x11/0x33/0x44 from reset. Grant order 0,2,3,0. Each tx_data is held constant while tx_busy=1.
- Enable warm-up: req[0] high while enable rises at cycle t. No tx_wr before t+2; tx_en=1 by t+1.
- Timeout: tx_busy tied 0, req[2]=1. Expect ack[2], then err pulse TIMEOUT cycles after WAIT_BUSY entry, no done, return to IDLE.
- Baud deferral: cfg_baud changes 3'b000->3'b111 mid-frame. baud_select stays 000 until the DONE->IDLE cycle, then becomes 111.
- Reset mid-frame: assert reset during WAIT_DONE. All outputs 0 within the same cycle (asynchronous), then normal operation after release.
